// File: rtl/mbus_int_req_arb.sv
// mbus_int_req_arb: latches N_SRC edge-triggered interrupt sources as
// pending, picks one at a time and runs the REQ_INT / accept / clear
// handshake with the MBus interrupt controller.
// Optional build macro: MBUS_INT_RR_EN selects round-robin arbitration
// (search starts after the last serviced source); when undefined the
// arbiter is fixed priority, lowest index wins.
module mbus_int_req_arb #(
  parameter int N_SRC   = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 64,
  parameter int HOLDOFF = 4
) (
  input  logic             CLKIN,
  input  logic             RESET,
  input  logic [N_SRC-1:0] SRC_REQ,
  input  logic [N_SRC-1:0] SRC_MASK,
  output logic             REQ_INT,
  input  logic             EXTERNAL_INT_TO_BUS,
  input  logic             CLR_EXT_INT,
  output logic [ID_W-1:0]  INT_ID,
  output logic             INT_ID_VALID,
  output logic             INT_DONE,
  output logic [N_SRC-1:0] INT_PENDING,
  output logic [N_SRC-1:0] SRC_DROP
);

  // Shared counter: REQ-phase timeout and HOLD-phase idle gap.
  localparam int CNT_MAX = (TIMEOUT > HOLDOFF) ? TIMEOUT : HOLDOFF;
  localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic [CNT_W-1:0] HO_LAST = (HOLDOFF > 0) ? CNT_W'(HOLDOFF - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ARB      = 3'd1,
    S_REQ      = 3'd2,
    S_WAIT_CLR = 3'd3,
    S_HOLD     = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_SRC-1:0] src_q;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [N_SRC-1:0] drop_q, drop_d;
  logic             req_int_q, req_int_d;
  logic [ID_W-1:0]  int_id_q, int_id_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;

  logic [N_SRC-1:0] rise_s;
  logic [N_SRC-1:0] elig_s;
  logic [N_SRC-1:0] clr_s;
  logic             accept_s;
  logic [ID_W-1:0]  win_s;

`ifdef MBUS_INT_RR_EN
  logic [ID_W-1:0]  ptr_q, ptr_d;

  // Rotate the eligible set so the pointer position is bit 0, then take the
  // lowest set bit and map it back to an absolute source index.
  function automatic logic [ID_W-1:0] pick_rr(input logic [N_SRC-1:0] elig,
                                              input logic [ID_W-1:0]  ptr);
    logic [2*N_SRC-1:0] dbl;
    logic [N_SRC-1:0]   rot;
    logic [ID_W:0]      sum;
    logic [ID_W-1:0]    pick;
    dbl  = {elig, elig} >> ptr;
    rot  = dbl[N_SRC-1:0];
    pick = '0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      sum  = {1'b0, ptr} + (ID_W+1)'(k);
      sum  = (sum >= (ID_W+1)'(N_SRC)) ? (sum - (ID_W+1)'(N_SRC)) : sum;
      pick = rot[k] ? sum[ID_W-1:0] : pick;
    end
    return pick;
  endfunction

  // Winner search begins at the round-robin pointer.
  always_comb begin
    win_s = pick_rr(elig_s, ptr_q);
  end

  // Pointer moves past the serviced source only on completion; retries keep it.
  always_comb begin
    ptr_d = ptr_q;
    if (done_d) begin
      ptr_d = (int_id_q == ID_W'(N_SRC - 1)) ? '0 : (int_id_q + ID_W'(1));
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge CLKIN) begin
    if (RESET) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  // Lowest eligible index wins; later (lower k) iterations override.
  function automatic logic [ID_W-1:0] pick_fixed(input logic [N_SRC-1:0] elig);
    logic [ID_W-1:0] pick;
    pick = '0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      pick = elig[k] ? ID_W'(k) : pick;
    end
    return pick;
  endfunction

  // Fixed-priority winner.
  always_comb begin
    win_s = pick_fixed(elig_s);
  end
`endif

  assign rise_s   = SRC_REQ & ~src_q;
  assign elig_s   = pending_q & ~SRC_MASK;
  assign accept_s = (state_q == S_REQ) && EXTERNAL_INT_TO_BUS;

  // Pending bookkeeping: accept clears the serviced bit, a new edge sets it
  // (set wins). An edge landing on a bit that is being cleared this cycle is
  // a fresh interrupt, not a lost one, so it is not reported as a drop.
  always_comb begin
    clr_s = '0;
    for (int i = 0; i < N_SRC; i++) begin
      clr_s[i] = accept_s && (int_id_q == ID_W'(i));
    end
    pending_d = (pending_q & ~clr_s) | rise_s;
    drop_d    = rise_s & pending_q & ~clr_s;
  end

  // Next-state and registered-output logic of the service FSM.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_int_d = req_int_q;
    int_id_d  = int_id_q;
    valid_d   = valid_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|elig_s) begin
          state_d = S_ARB;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ARB: begin
        if (|elig_s) begin
          int_id_d  = win_s;
          valid_d   = 1'b1;
          cnt_d     = '0;
          req_int_d = 1'b1;
          state_d   = S_REQ;
        end else begin
          valid_d   = 1'b0;
          state_d   = S_IDLE;
        end
      end
      S_REQ: begin
        if (EXTERNAL_INT_TO_BUS) begin
          req_int_d = 1'b0;
          cnt_d     = '0;
          state_d   = S_WAIT_CLR;
        end else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
          req_int_d = 1'b0;
          valid_d   = 1'b0;
          cnt_d     = '0;
          state_d   = S_HOLD;
        end else if (TIMEOUT != 0) begin
          cnt_d     = cnt_q + CNT_W'(1);
        end else begin
          cnt_d     = cnt_q;
        end
      end
      S_WAIT_CLR: begin
        if (CLR_EXT_INT) begin
          done_d  = 1'b1;
          valid_d = 1'b0;
          cnt_d   = '0;
          state_d = S_HOLD;
        end else begin
          state_d = S_WAIT_CLR;
        end
      end
      S_HOLD: begin
        if ((HOLDOFF == 0) || (cnt_q == HO_LAST)) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d   = S_IDLE;
        cnt_d     = '0;
        req_int_d = 1'b0;
        valid_d   = 1'b0;
      end
    endcase
  end

  // State, counter, edge history, pending and output registers.
  always_ff @(posedge CLKIN) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      src_q     <= '0;
      pending_q <= '0;
      drop_q    <= '0;
      req_int_q <= 1'b0;
      int_id_q  <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      src_q     <= SRC_REQ;
      pending_q <= pending_d;
      drop_q    <= drop_d;
      req_int_q <= req_int_d;
      int_id_q  <= int_id_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
    end
  end

  assign REQ_INT      = req_int_q;
  assign INT_ID       = int_id_q;
  assign INT_ID_VALID = valid_q;
  assign INT_DONE     = done_q;
  assign INT_PENDING  = pending_q;
  assign SRC_DROP     = drop_q;

endmodule

// File: tb/tb_mbus_int_req_arb.sv
// Directed bench for mbus_int_req_arb (TIMEOUT=8, HOLDOFF=4). Expected
// orderings depend on whether MBUS_INT_RR_EN is defined.
module tb_mbus_int_req_arb;

`ifdef MBUS_INT_RR_EN
  localparam logic [31:0] T2_FIRST  = 32'd3;
  localparam logic [31:0] T2_SECOND = 32'd1;
  localparam logic [31:0] T3_FIRST  = 32'd2;
  localparam logic [31:0] T3_SECOND = 32'd0;
`else
  localparam logic [31:0] T2_FIRST  = 32'd1;
  localparam logic [31:0] T2_SECOND = 32'd3;
  localparam logic [31:0] T3_FIRST  = 32'd0;
  localparam logic [31:0] T3_SECOND = 32'd2;
`endif

  logic       CLKIN;
  logic       RESET;
  logic [3:0] SRC_REQ;
  logic [3:0] SRC_MASK;
  logic       REQ_INT;
  logic       EXTERNAL_INT_TO_BUS;
  logic       CLR_EXT_INT;
  logic [1:0] INT_ID;
  logic       INT_ID_VALID;
  logic       INT_DONE;
  logic [3:0] INT_PENDING;
  logic [3:0] SRC_DROP;

  int n_total   = 0;
  int n_pass    = 0;
  int n_fail    = 0;
  bit done_seen = 1'b0;

  mbus_int_req_arb #(
    .N_SRC(4), .ID_W(2), .TIMEOUT(8), .HOLDOFF(4)
  ) dut (
    .CLKIN(CLKIN), .RESET(RESET), .SRC_REQ(SRC_REQ), .SRC_MASK(SRC_MASK),
    .REQ_INT(REQ_INT), .EXTERNAL_INT_TO_BUS(EXTERNAL_INT_TO_BUS),
    .CLR_EXT_INT(CLR_EXT_INT), .INT_ID(INT_ID), .INT_ID_VALID(INT_ID_VALID),
    .INT_DONE(INT_DONE), .INT_PENDING(INT_PENDING), .SRC_DROP(SRC_DROP)
  );

  initial CLKIN = 1'b0;
  always #5 CLKIN = ~CLKIN;

  task automatic step();
    @(posedge CLKIN);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for REQ_INT; n = edges waited.
  task automatic wait_req(input string tag, output int n);
    n = 0;
    while (REQ_INT !== 1'b1 && n < 64) begin
      step();
      n++;
      if (INT_DONE === 1'b1) done_seen = 1'b1;
    end
    chk(tag, 32'(REQ_INT), 32'd1);
  endtask

  // Accept then clear the current request; checks ID and the DONE pulse.
  task automatic handshake(input string tag, input logic [31:0] exp_id);
    chk({tag, "_id"}, 32'(INT_ID), exp_id);
    chk({tag, "_valid"}, 32'(INT_ID_VALID), 32'd1);
    EXTERNAL_INT_TO_BUS = 1'b1;
    step();
    EXTERNAL_INT_TO_BUS = 1'b0;
    chk({tag, "_req_drop"}, 32'(REQ_INT), 32'd0);
    CLR_EXT_INT = 1'b1;
    step();
    CLR_EXT_INT = 1'b0;
    chk({tag, "_done"}, 32'(INT_DONE), 32'd1);
    chk({tag, "_valid_off"}, 32'(INT_ID_VALID), 32'd0);
  endtask

  initial begin
    int n;
    int hi;
    bit req_seen;
    RESET = 1'b1; SRC_REQ = 4'b0000; SRC_MASK = 4'b0000;
    EXTERNAL_INT_TO_BUS = 1'b0; CLR_EXT_INT = 1'b0;
    step(); step();
    chk("rst_req",     32'(REQ_INT),      32'd0);
    chk("rst_valid",   32'(INT_ID_VALID), 32'd0);
    chk("rst_done",    32'(INT_DONE),     32'd0);
    chk("rst_id",      32'(INT_ID),       32'd0);
    chk("rst_pending", 32'(INT_PENDING),  32'd0);
    chk("rst_drop",    32'(SRC_DROP),     32'd0);
    RESET = 1'b0;

    // Single request on source 2, exact latency.
    SRC_REQ = 4'b0100;
    step();
    chk("t1_pend_k",  32'(INT_PENDING), 32'h4);
    chk("t1_req_k",   32'(REQ_INT),     32'd0);
    step();
    chk("t1_req_k1",  32'(REQ_INT),     32'd0);
    step();
    chk("t1_req_k2",  32'(REQ_INT),     32'd1);
    handshake("t1", 32'd2);
    chk("t1_pend_after", 32'(INT_PENDING), 32'd0);
    step();
    chk("t1_done_pulse", 32'(INT_DONE), 32'd0);

    // Two sources rise together; ordering and inter-service gap.
    SRC_REQ = 4'b1010;
    wait_req("t2_wait1", n);
    handshake("t2a", T2_FIRST);
    chk("t2_pend_mid", 32'(INT_PENDING), 32'(4'b1010) & ~(32'd1 << T2_FIRST));
    wait_req("t2_wait2", n);
    chk("t2_gap", 32'(n), 32'd6);
    handshake("t2b", T2_SECOND);
    chk("t2_pend_end", 32'(INT_PENDING), 32'd0);

    // Source 0 serviced, then sources 0 and 2 together.
    SRC_REQ = 4'b0001;
    wait_req("t3_wait0", n);
    handshake("t3a", 32'd0);
    SRC_REQ = 4'b0000;
    step();
    SRC_REQ = 4'b0101;
    wait_req("t3_wait1", n);
    handshake("t3b", T3_FIRST);
    wait_req("t3_wait2", n);
    handshake("t3c", T3_SECOND);

    // Drop pulse, then timeout retry with accept held low.
    done_seen = 1'b0;
    SRC_REQ = 4'b0000;
    step();
    SRC_REQ = 4'b0010;
    step();
    chk("t4_pend", 32'(INT_PENDING), 32'h2);
    SRC_REQ = 4'b0000;
    step();
    SRC_REQ = 4'b0010;
    step();
    chk("t4_drop_pulse", 32'(SRC_DROP), 32'h2);
    step();
    chk("t4_drop_clear", 32'(SRC_DROP), 32'h0);
    SRC_REQ = 4'b0000;
    wait_req("t4_wait", n);
    chk("t4_req_start", 32'(n >= 1), 32'd1);
    hi = 1;
    for (int i = 0; i < 30; i++) begin
      step();
      if (INT_DONE === 1'b1) done_seen = 1'b1;
      if (REQ_INT === 1'b1) hi++;
      else break;
    end
    chk("t4_req_width",  32'(hi),           32'd8);
    chk("t4_pend_kept",  32'(INT_PENDING),  32'h2);
    chk("t4_valid_off",  32'(INT_ID_VALID), 32'd0);
    wait_req("t4_retry", n);
    chk("t4_retry_gap",  32'(n),            32'd6);
    chk("t4_no_done",    32'(done_seen),    32'd0);
    chk("t4_retry_id",   32'(INT_ID),       32'd1);

    // Set wins: new edge on source 1 in the accept cycle.
    EXTERNAL_INT_TO_BUS = 1'b1;
    SRC_REQ = 4'b0010;
    step();
    EXTERNAL_INT_TO_BUS = 1'b0;
    chk("t5_req_off",   32'(REQ_INT),     32'd0);
    chk("t5_set_wins",  32'(INT_PENDING), 32'h2);
    CLR_EXT_INT = 1'b1;
    step();
    CLR_EXT_INT = 1'b0;
    chk("t5_done", 32'(INT_DONE), 32'd1);
    wait_req("t5_wait_again", n);
    handshake("t5b", 32'd1);
    chk("t5_pend_end", 32'(INT_PENDING), 32'd0);
    SRC_REQ = 4'b0000;

    // Masked pending source is held off until unmasked.
    SRC_MASK = 4'b0001;
    SRC_REQ = 4'b0001;
    req_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (REQ_INT === 1'b1) req_seen = 1'b1;
    end
    chk("t6_masked_noreq", 32'(req_seen),    32'd0);
    chk("t6_masked_pend",  32'(INT_PENDING), 32'h1);
    SRC_MASK = 4'b0000;
    wait_req("t6_unmask", n);
    chk("t6_unmask_lat", 32'(n),      32'd2);
    chk("t6_id",         32'(INT_ID), 32'd0);
    SRC_REQ = 4'b1001;
    EXTERNAL_INT_TO_BUS = 1'b1;
    step();
    EXTERNAL_INT_TO_BUS = 1'b0;
    chk("t6_pend_wait", 32'(INT_PENDING), 32'h8);

    // Reset while waiting for clear: everything zero, no DONE.
    RESET = 1'b1;
    CLR_EXT_INT = 1'b1;
    SRC_REQ = 4'b0000;
    step();
    chk("t7_req",   32'(REQ_INT),      32'd0);
    chk("t7_valid", 32'(INT_ID_VALID), 32'd0);
    chk("t7_done",  32'(INT_DONE),     32'd0);
    chk("t7_id",    32'(INT_ID),       32'd0);
    chk("t7_pend",  32'(INT_PENDING),  32'd0);
    chk("t7_drop",  32'(SRC_DROP),     32'd0);
    RESET = 1'b0;
    CLR_EXT_INT = 1'b0;
    step();
    chk("t7_done_after", 32'(INT_DONE), 32'd0);
    chk("t7_req_after",  32'(REQ_INT),  32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
